mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM stage load/store unit. It consumes the EX/MEM pipeline register outputs and runs data-memory accesses on a req/ack bus.
- It handles byte, half and word access: lane alignment, byte enables, sign/zero extension.
- It registers results into the MEM/WB boundary and stalls the pipeline (EX/MEM and earlier hold) while an access is outstanding.

Parameters:
- TIMEOUT, 16, REQ cycles without d_ack before a bus error is declared (minimum 2).
- CNT_W, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- mem_pc  in  32  instruction PC from EX/MEM
- mem_reg_addr  in  5  destination register
- mem_control  in  8  [0]=reg_write, [1]=R-type, [2]=mem_read, [3]=mem_write, [7:4] passed through
- mem_alu_result  in  32  effective address / ALU result
- mem_write_data  in  32  store data (rs2)
- mem_ls  in  2  00=byte, 01=half, 10=word, 11=word
- mem_sign_flag  in  1  1=sign-extend load, 0=zero-extend
- d_req  out  1  bus request (registered)
- d_we  out  1  1=store
- d_addr  out  32  word-aligned address {addr[31:2],2'b00}
- d_be  out  4  byte enables
- d_wdata  out  32  lane-replicated store data
- d_ack  in  1  bus completion, 1-cycle pulse
- d_rdata  in  32  read data, valid with d_ack
- mem_stall  out  1  hold EX/MEM and upstream stages
- wb_pc, wb_reg_addr, wb_control, wb_alu_result  out  32/5/8/32  registered pass-through
- wb_load_data  out  32  extended load result
- mem_exc  out  1  registered 1-cycle pulse: misaligned access or bus timeout
- exc_cause  out  1  0=misaligned, 1=timeout

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0, FSM=IDLE, counter 0. Reset during REQ drops d_req immediately and abandons the access.
- access = control[2] | control[3]. Store wins if both bits are set.
- misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- FSM states: IDLE, REQ, DONE.
  - IDLE, no access: WB registers capture inputs each edge; mem_stall=0.
  - IDLE, misaligned access: no bus cycle. WB captures with wb_control[0] forced 0, mem_exc=1, exc_cause=0, mem_stall=0.
  - IDLE, aligned access: mem_stall=1 combinationally. At next edge: ->REQ; d_req, d_we, d_addr, d_be, d_wdata registered and held stable through REQ.
  - REQ: mem_stall=1; counter increments each cycle.
    - d_ack=1: capture d_rdata, d_req<=0, ->DONE.
    - counter==TIMEOUT-1 without ack: d_req<=0, load data 0, flag error, ->DONE.
  - DONE: mem_stall=0. At edge: WB registers capture (wb_load_data extended; reg_write cleared on error; mem_exc/exc_cause=1 on error), ->IDLE, counter cleared.
- Latency: non-memory instructions 1 cycle. Access with ack in first REQ cycle: 3 cycles (2 stalled). Each extra wait state adds 1.
- d_ack outside REQ is ignored.
- Store lanes, off = addr[1:0]:
  - byte: d_wdata = {4{wd[7:0]}}, d_be = 0001<<off.
  - half: d_wdata = {2{wd[15:0]}}, d_be = 0011<<off.
  - word: d_be = 1111.
- Load: shifted = rdata >> (8*off); take low 8/16/32 bits; sign- or zero-extend per mem_sign_flag. Stores write wb_load_data=0.
- mem_exc lasts exactly one cycle.

Decomposition:
- Package riscv_mem_pkg:
  - LS_BYTE/LS_HALF/LS_WORD codes
  - control bit indices CTL_REG_WRITE=0, CTL_RTYPE=1, CTL_MEM_READ=2, CTL_MEM_WRITE=3
  - FSM state encoding
  - exception cause codes
- Sub-module lsu_align (combinational): store lane replication + d_be generation, load shift + extension, misaligned detect. The FSM, counter and WB registers stay in mem_stage_lsu.

Test Plan:
- ADD, control=0x03, alu=0x1234 -> next cycle wb_alu_result=0x1234, wb_control=0x03, mem_stall never 1.
- LB, addr=0x103, sign=1, ls=00, ack first REQ cycle, rdata=0x80FFFFFF -> d_addr=0x100, d_be=0000 (load), 2 stall cycles, wb_load_data=0xFFFFFF80. Repeat with sign=0 -> 0x00000080.
- SH, addr=0x202, wd=0x0000BEEF, ack after 3 wait cycles -> d_we=1, d_be=1100, d_wdata=0xBEEFBEEF, mem_stall high 5 cycles, d_req held 4 cycles.
- LW, addr=0x301 -> no d_req, mem_exc pulse with exc_cause=0, wb_control[0]=0, no stall.
- LW with d_ack never asserted, TIMEOUT=16 -> d_req drops after 16 REQ cycles, mem_exc=1 with exc_cause=1, wb_load_data=0, reg_write cleared.
- rst_n low during REQ -> d_req=0 and mem_stall=0 asynchronously, all wb_* outputs 0. A later access after release completes normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared encodings for the MEM stage load/store unit
package riscv_mem_pkg;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
  localparam int CTL_REG_WRITE = 0;
  localparam int CTL_RTYPE = 1;
  localparam int CTL_MEM_READ = 2;
  localparam int CTL_MEM_WRITE = 3;
  localparam logic EXC_MISALIGN = 1'b0;
  localparam logic EXC_TIMEOUT = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication, byte enables, load shift/extend and misalignment detect
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  ls,
  input  logic [1:0]  off,
  input  logic        sign,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load,
  output logic        misaligned
);
  logic [31:0] sh;
  always_comb begin
    wdata = ls == LS_BYTE ? {4{wd[7:0]}} : ls == LS_HALF ? {2{wd[15:0]}} : wd;
    be = ls == LS_BYTE ? 4'b0001 << off : ls == LS_HALF ? 4'b0011 << off : 4'b1111;
    sh = rdata >> {off, 3'b000};
    load = ls == LS_BYTE ? {{24{sign & sh[7]}}, sh[7:0]} :
           ls == LS_HALF ? {{16{sign & sh[15]}}, sh[15:0]} : sh;
    misaligned = (ls == LS_HALF & off[0]) | (ls[1] & off != 2'b00);
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage load/store unit on a req/ack data bus with MEM/WB registers
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_pc,
  input  logic [4:0]  mem_reg_addr,
  input  logic [7:0]  mem_control,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [1:0]  mem_ls,
  input  logic        mem_sign_flag,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_reg_addr,
  output logic [7:0]  wb_control,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic        mem_exc,
  output logic        exc_cause
);
  lsu_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] rdata_q, st_data, ld_data;
  logic [3:0] st_be;
  logic err, misaligned, is_store, access;
  assign is_store = mem_control[CTL_MEM_WRITE];
  assign access = mem_control[CTL_MEM_READ] | is_store;
  assign mem_stall = rst_n & (state == ST_REQ | (state == ST_IDLE & access & !misaligned));
  lsu_align u_align (
    .ls(mem_ls),
    .off(mem_alu_result[1:0]),
    .sign(mem_sign_flag),
    .wd(mem_write_data),
    .rdata(rdata_q),
    .wdata(st_data),
    .be(st_be),
    .load(ld_data),
    .misaligned(misaligned)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      rdata_q <= '0;
      err <= 1'b0;
      d_req <= 1'b0;
      d_we <= 1'b0;
      d_addr <= '0;
      d_be <= '0;
      d_wdata <= '0;
      wb_pc <= '0;
      wb_reg_addr <= '0;
      wb_control <= '0;
      wb_alu_result <= '0;
      wb_load_data <= '0;
      mem_exc <= 1'b0;
      exc_cause <= 1'b0;
    end else begin
      mem_exc <= 1'b0;
      exc_cause <= EXC_MISALIGN;
      case (state)
        ST_IDLE:
          if (access & !misaligned) begin
            state <= ST_REQ;
            cnt <= '0;
            d_req <= 1'b1;
            d_we <= is_store;
            d_addr <= {mem_alu_result[31:2], 2'b00};
            d_be <= is_store ? st_be : 4'b0000;
            d_wdata <= st_data;
          end else begin
            wb_pc <= mem_pc;
            wb_reg_addr <= mem_reg_addr;
            wb_control <= {mem_control[7:1], mem_control[CTL_REG_WRITE] & !access};
            wb_alu_result <= mem_alu_result;
            wb_load_data <= '0;
            mem_exc <= access;
          end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (d_ack | cnt == CNT_W'(TIMEOUT - 1)) begin
            d_req <= 1'b0;
            rdata_q <= d_ack ? d_rdata : '0;
            err <= !d_ack;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          wb_pc <= mem_pc;
          wb_reg_addr <= mem_reg_addr;
          wb_control <= {mem_control[7:1], mem_control[CTL_REG_WRITE] & !err};
          wb_alu_result <= mem_alu_result;
          wb_load_data <= is_store | err ? '0 : ld_data;
          mem_exc <= err;
          exc_cause <= err ? EXC_TIMEOUT : EXC_MISALIGN;
          cnt <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench with a byte-level memory reference model and random bus latency
module tb_mem_stage_lsu;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst_n = 0;
  logic [31:0] mem_pc = 0, mem_alu_result = 0, mem_write_data = 0;
  logic [4:0] mem_reg_addr = 0;
  logic [7:0] mem_control = 0;
  logic [1:0] mem_ls = 0;
  logic mem_sign_flag = 0;
  logic d_req, d_we, d_ack = 0, mem_stall, mem_exc, exc_cause;
  logic [31:0] d_addr, d_wdata, d_rdata = 0, wb_pc, wb_alu_result, wb_load_data;
  logic [3:0] d_be;
  logic [4:0] wb_reg_addr;
  logic [7:0] wb_control;
  always #5 clk = ~clk;
  mem_stage_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_pc(mem_pc), .mem_reg_addr(mem_reg_addr),
    .mem_control(mem_control), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_ls(mem_ls), .mem_sign_flag(mem_sign_flag),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .mem_stall(mem_stall), .wb_pc(wb_pc),
    .wb_reg_addr(wb_reg_addr), .wb_control(wb_control), .wb_alu_result(wb_alu_result),
    .wb_load_data(wb_load_data), .mem_exc(mem_exc), .exc_cause(exc_cause)
  );
  typedef struct {
    logic [31:0] pc, alu, load;
    logic [4:0] rd;
    logic [7:0] ctl;
    logic exc, cause;
    int stalls;
  } wb_t;
  typedef struct {
    logic we;
    logic [31:0] addr, wdata;
    logic [3:0] be;
  } bus_t;
  wb_t exp_q[$];
  bus_t bus_q[$];
  int lat_q[$];
  logic [7:0] mem [0:1023];
  int checks = 0, errors = 0;
  bit running = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic nop();
    mem_control = 8'h00;
  endtask
  // Reference: memory is a byte array; expected WB/bus values come from plain byte arithmetic.
  task automatic issue(logic [7:0] ctl, logic [31:0] alu, logic [31:0] wd, logic [1:0] ls,
                       logic sgn, int w);
    wb_t e;
    bus_t b;
    int n, a, cyc;
    logic [31:0] v;
    bit acc, st, s;
    n = ls == 2'b00 ? 1 : ls == 2'b01 ? 2 : 4;
    acc = ctl[2] | ctl[3];
    st = ctl[3];
    mem_pc = $urandom;
    mem_reg_addr = 5'($urandom);
    mem_control = ctl;
    mem_alu_result = alu;
    mem_write_data = wd;
    mem_ls = ls;
    mem_sign_flag = sgn;
    e.pc = mem_pc; e.rd = mem_reg_addr; e.ctl = ctl; e.alu = alu;
    e.load = 0; e.exc = 0; e.cause = 0; e.stalls = 0;
    if (acc && (alu & 32'(n - 1)) != 0) begin
      e.ctl[0] = 1'b0;
      e.exc = 1'b1;
    end else if (acc) begin
      e.stalls = 1 + (w < TIMEOUT ? w + 1 : TIMEOUT);
      a = int'(alu[9:0]);
      b.we = st;
      b.addr = {alu[31:2], 2'b00};
      b.be = st ? 4'(((1 << n) - 1) << alu[1:0]) : 4'b0000;
      b.wdata = n == 1 ? {4{wd[7:0]}} : n == 2 ? {2{wd[15:0]}} : wd;
      if (w >= TIMEOUT) begin
        e.ctl[0] = 1'b0;
        e.exc = 1'b1;
        e.cause = 1'b1;
      end else if (st) begin
        for (int i = 0; i < n; i++) mem[a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mem[a + i]) << (8 * i));
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        e.load = v;
      end
      bus_q.push_back(b);
      lat_q.push_back(w);
    end
    exp_q.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      s = mem_stall;
      @(posedge clk);
      cyc++;
      if (cyc > 100) begin
        $display("FAIL stall_bound: instruction still stalled after %0d cycles", cyc);
        $fatal(1, "stall bound exceeded");
      end
    end while (s);
    #1;
  endtask
  // Monitor: WB registers reflect an instruction after every edge that saw mem_stall low.
  bit cap = 0;
  int stalls = 0;
  wb_t m;
  always @(negedge clk) begin
    if (!rst_n) begin
      cap = 0;
      stalls = 0;
    end else begin
      if (cap) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_capture: unexpected capture, pc %h", wb_pc);
        end else begin
          m = exp_q.pop_front();
          check("wb_pc", wb_pc, m.pc);
          check("wb_reg_addr", 32'(wb_reg_addr), 32'(m.rd));
          check("wb_control", 32'(wb_control), 32'(m.ctl));
          check("wb_alu_result", wb_alu_result, m.alu);
          check("wb_load_data", wb_load_data, m.load);
          check("mem_exc", 32'(mem_exc), 32'(m.exc));
          check("exc_cause", 32'(exc_cause), 32'(m.cause));
          check("stall_cycles", 32'(stalls), 32'(m.stalls));
        end
        stalls = 0;
      end else begin
        check("exc_pulse", 32'(mem_exc), 32'd0);
      end
      if (mem_stall) stalls++;
      cap = !mem_stall && running;
    end
  end
  // Bus responder: acks after the chosen number of wait states, or never for timeout cases.
  int k = 0, w = 0, a = 0;
  bit active = 0, acked = 0;
  bus_t rb;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
      d_ack = 0;
    end else if (d_req) begin
      if (!active) begin
        active = 1;
        k = 0;
        acked = 0;
        if (lat_q.size() == 0 || bus_q.size() == 0) begin
          errors++;
          $display("FAIL bus_req: unexpected request to %h", d_addr);
          w = 0;
        end else begin
          w = lat_q.pop_front();
          rb = bus_q.pop_front();
          check("d_we", 32'(d_we), 32'(rb.we));
          check("d_addr", d_addr, rb.addr);
          check("d_be", 32'(d_be), 32'(rb.be));
          if (rb.we) check("d_wdata", d_wdata, rb.wdata);
        end
      end
      k++;
      acked = (k == w + 1);
      a = int'({d_addr[9:2], 2'b00});
      d_ack = acked;
      d_rdata = acked ? {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]} : $urandom;
    end else begin
      if (active && !acked) check("req_cycles", 32'(k), 32'(TIMEOUT));
      active = 0;
      d_ack = ($urandom_range(0, 7) == 0);
      d_rdata = $urandom;
    end
  end
  initial begin
    logic [7:0] ctl;
    logic [31:0] alu;
    logic [1:0] ls;
    int kind, n, lat;
    bus_t b;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[256] = 8'hFF; mem[257] = 8'hFF; mem[258] = 8'hFF; mem[259] = 8'h80;
    #12;
    check("rst_d_req", 32'(d_req), 32'd0);
    check("rst_d_addr", d_addr, 32'd0);
    check("rst_d_be", 32'(d_be), 32'd0);
    check("rst_wb_pc", wb_pc, 32'd0);
    check("rst_wb_control", 32'(wb_control), 32'd0);
    check("rst_wb_load_data", wb_load_data, 32'd0);
    check("rst_mem_exc", 32'(mem_exc), 32'd0);
    check("rst_mem_stall", 32'(mem_stall), 32'd0);
    #5 rst_n = 1;
    @(posedge clk);
    #1 running = 1;
    issue(8'h03, 32'h0000_1234, 32'h0, 2'b10, 1'b0, 0);
    issue(8'h05, 32'h0000_0103, 32'h0, 2'b00, 1'b1, 0);
    issue(8'h05, 32'h0000_0103, 32'h0, 2'b00, 1'b0, 0);
    issue(8'h08, 32'h0000_0202, 32'h0000_BEEF, 2'b01, 1'b0, 3);
    issue(8'h05, 32'h0000_0301, 32'h0, 2'b10, 1'b0, 0);
    issue(8'h05, 32'h0000_0300, 32'h0, 2'b10, 1'b0, 100);
    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 3);
      ctl = 8'($urandom);
      ctl[3:2] = kind == 0 ? 2'b00 : kind == 1 ? 2'b01 : kind == 2 ? 2'b10 : 2'b11;
      ls = 2'($urandom);
      n = ls == 2'b00 ? 1 : ls == 2'b01 ? 2 : 4;
      alu = $urandom;
      if ($urandom_range(0, 4) != 0) alu = alu & ~32'(n - 1);
      lat = $urandom_range(0, 19) == 0 ? 40 : $urandom_range(0, 4);
      issue(ctl, alu, $urandom, ls, 1'($urandom), lat);
    end
    running = 0;
    nop();
    @(posedge clk);
    #1;
    mem_control = 8'h05;
    mem_alu_result = 32'h0000_0300;
    mem_ls = 2'b10;
    b.we = 0; b.addr = 32'h0000_0300; b.be = 4'b0000; b.wdata = 0;
    bus_q.push_back(b);
    lat_q.push_back(100);
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_d_req", 32'(d_req), 32'd0);
    check("arst_mem_stall", 32'(mem_stall), 32'd0);
    check("arst_wb_pc", wb_pc, 32'd0);
    check("arst_wb_alu_result", wb_alu_result, 32'd0);
    check("arst_wb_control", 32'(wb_control), 32'd0);
    check("arst_wb_reg_addr", 32'(wb_reg_addr), 32'd0);
    check("arst_wb_load_data", wb_load_data, 32'd0);
    nop();
    lat_q.delete();
    bus_q.delete();
    @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1 running = 1;
    issue(8'h05, 32'h0000_0104, 32'h0, 2'b10, 1'b0, 1);
    for (int i = 0; i < 30; i++) begin
      ctl = 8'($urandom);
      ctl[3:2] = 2'($urandom);
      alu = $urandom & 32'hFFFF_FFFC;
      issue(ctl, alu, $urandom, 2'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    running = 0;
    nop();
    repeat (4) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
